// File: rtl/approx_mult_err_profiler_pkg.sv
// approx_mult_err_profiler_pkg: shared types and helpers for the approximate-multiplier error profiler
package approx_mult_err_profiler_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    function automatic longint unsigned pair_total(input int unsigned w, input logic tri_m);
        longint unsigned n;
        n = (64'd1 << w) - 64'd1;
        return tri_m ? n * (n + 64'd1) / 64'd2 : n * n;
    endfunction
    // Increment permitted only while below the all-ones ceiling of a cw-bit counter
    function automatic logic sat_step(input logic [63:0] v, input logic inc, input int unsigned cw);
        return inc && (v != ((64'd1 << cw) - 64'd1));
    endfunction
endpackage

// File: rtl/approx_mult_err_profiler_err_bit_counter_bank.sv
// approx_mult_err_profiler_err_bit_counter_bank: per-bit saturating mismatch counters with indexed read
module approx_mult_err_profiler_err_bit_counter_bank
    import approx_mult_err_profiler_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int IW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N-1:0]     inc,
    input  logic [IW-1:0]    rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             ovf
);
    logic [CNT_W-1:0] cnt [N];
    logic [N-1:0]     lost;
    for (genvar i = 0; i < N; i++) begin : g_cnt
        logic step;
        assign step    = sat_step(64'(cnt[i]), inc[i], CNT_W);
        assign lost[i] = inc[i] & ~step;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)   cnt[i] <= '0;
            else if (clr) cnt[i] <= '0;
            else          cnt[i] <= cnt[i] + CNT_W'(step);
    end
    assign ovf    = |lost;
    assign rd_cnt = (32'(rd_idx) < N) ? cnt[rd_idx] : '0;
endmodule

// File: rtl/approx_mult_err_profiler.sv
// approx_mult_err_profiler: sweeps all non-zero operand pairs through an external approximate multiplier and profiles its error
module approx_mult_err_profiler
    import approx_mult_err_profiler_pkg::*;
#(
    parameter int W     = 8,
    parameter int PW    = 2*W-1,
    parameter int LAT   = 0,
    parameter int CNT_W = 32,
    parameter int IW    = $clog2(2*W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_tri,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [PW-1:0]    approx_prod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] err_pairs,
    output logic [2*W-1:0]   max_abs_err,
    output logic             sat,
    input  logic [IW-1:0]    rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);
    localparam int EW = 2*W;
    state_t        state;
    logic          tri_q, acc, issue, av, pipe_busy, cv_q, pc_step, ep_step, bank_ovf, lost;
    logic [W-1:0]  b_lim;
    logic [EW-1:0] exact, ae, ax, diff, absd, diff_q, abs_q;
    assign acc   = start && (state == S_IDLE || state == S_DONE);
    assign issue = state == S_RUN;
    assign b_lim = tri_q ? op_a : '1;
    assign exact = EW'(op_a) * EW'(op_b);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            tri_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    state <= S_RUN;
                    op_a  <= W'(1);
                    op_b  <= W'(1);
                    tri_q <= mode_tri;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end
                S_RUN: if (op_b == b_lim) begin
                    if (&op_a) state <= S_DRAIN;
                    else begin
                        op_a <= op_a + W'(1);
                        op_b <= W'(1);
                    end
                end else op_b <= op_b + W'(1);
                S_DRAIN: if (!pipe_busy && !cv_q) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    // Exact product travels alongside the external multiplier's latency
    if (LAT == 0) begin : g_nolat
        assign av        = issue;
        assign ae        = exact;
        assign pipe_busy = 1'b0;
    end else begin : g_lat
        logic [LAT-1:0] vp;
        logic [EW-1:0]  ep [LAT];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                vp <= '0;
                for (int k = 0; k < LAT; k++) ep[k] <= '0;
            end else begin
                vp[0] <= issue;
                ep[0] <= exact;
                for (int k = 1; k < LAT; k++) begin
                    vp[k] <= vp[k-1];
                    ep[k] <= ep[k-1];
                end
            end
        assign av        = vp[LAT-1];
        assign ae        = ep[LAT-1];
        assign pipe_busy = |vp;
    end
    assign ax      = EW'(approx_prod);
    assign diff    = ae ^ ax;
    assign absd    = ae >= ax ? ae - ax : ax - ae;
    assign pc_step = sat_step(64'(pair_count), cv_q, CNT_W);
    assign ep_step = sat_step(64'(err_pairs), cv_q & (|diff_q), CNT_W);
    assign lost    = (cv_q & ~pc_step) | (cv_q & (|diff_q) & ~ep_step) | bank_ovf;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cv_q        <= 1'b0;
            diff_q      <= '0;
            abs_q       <= '0;
            pair_count  <= '0;
            err_pairs   <= '0;
            max_abs_err <= '0;
            sat         <= 1'b0;
        end else begin
            cv_q   <= av;
            diff_q <= diff;
            abs_q  <= absd;
            if (acc) begin
                pair_count  <= '0;
                err_pairs   <= '0;
                max_abs_err <= '0;
                sat         <= 1'b0;
            end else begin
                pair_count <= pair_count + CNT_W'(pc_step);
                err_pairs  <= err_pairs + CNT_W'(ep_step);
                if (cv_q && abs_q > max_abs_err) max_abs_err <= abs_q;
                sat <= sat | lost;
            end
        end
    approx_mult_err_profiler_err_bit_counter_bank #(.N(EW), .CNT_W(CNT_W), .IW(IW)) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc),
        .inc    (diff_q & {EW{cv_q}}),
        .rd_idx (rd_idx),
        .rd_cnt (rd_cnt),
        .ovf    (bank_ovf)
    );
endmodule

// File: tb/tb_approx_mult_err_profiler.sv
// tb_approx_mult_err_profiler: three W=4 profilers (LAT=0, LAT=2, CNT_W=6) checked against an enumerating reference model
module tb_approx_mult_err_profiler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [3];
    logic        mode_tri [3];
    logic        busy [3];
    logic        done [3];
    logic        sat [3];
    logic [3:0]  op_a [3];
    logic [3:0]  op_b [3];
    logic [2:0]  rd_idx [3];
    logic [7:0]  max_err [3];
    logic [6:0]  ap0, ap1, ap2, d1;
    logic [31:0] pc [2];
    logic [31:0] ep [2];
    logic [31:0] rc [2];
    logic [5:0]  pc2, ep2, rc2;
    logic [6:0]  lut [256];
    int          kind [3];
    int          errors = 0;
    int          checks = 0;
    int          e_pairs, e_pc, e_ep, e_max;
    int          e_bit [8];
    bit          e_sat;

    always #5 clk = ~clk;

    function automatic logic [6:0] approx_f(input int k, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'(a) * 8'(b);
        case (k)
            0:       return p[6:0];
            1:       return p[6:0] & 7'h7E;
            2:       return 7'h7F;
            default: return p[6:0] ^ lut[{a, b}];
        endcase
    endfunction

    assign ap0 = approx_f(kind[0], op_a[0], op_b[0]);
    assign ap2 = approx_f(kind[2], op_a[2], op_b[2]);
    always @(posedge clk) begin
        d1  <= approx_f(kind[1], op_a[1], op_b[1]);
        ap1 <= d1;
    end

    approx_mult_err_profiler #(.W(4), .LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode_tri(mode_tri[0]), .op_a(op_a[0]), .op_b(op_b[0]),
        .approx_prod(ap0), .busy(busy[0]), .done(done[0]), .pair_count(pc[0]), .err_pairs(ep[0]),
        .max_abs_err(max_err[0]), .sat(sat[0]), .rd_idx(rd_idx[0]), .rd_cnt(rc[0]));
    approx_mult_err_profiler #(.W(4), .LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode_tri(mode_tri[1]), .op_a(op_a[1]), .op_b(op_b[1]),
        .approx_prod(ap1), .busy(busy[1]), .done(done[1]), .pair_count(pc[1]), .err_pairs(ep[1]),
        .max_abs_err(max_err[1]), .sat(sat[1]), .rd_idx(rd_idx[1]), .rd_cnt(rc[1]));
    approx_mult_err_profiler #(.W(4), .LAT(0), .CNT_W(6)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode_tri(mode_tri[2]), .op_a(op_a[2]), .op_b(op_b[2]),
        .approx_prod(ap2), .busy(busy[2]), .done(done[2]), .pair_count(pc2), .err_pairs(ep2),
        .max_abs_err(max_err[2]), .sat(sat[2]), .rd_idx(rd_idx[2]), .rd_cnt(rc2));

    // Enumerate every pair the sweep should visit and tally mismatches, then clamp to the counter ceiling
    task automatic model(input int k, input bit tri_m, input longint cmax);
        longint t_pc, t_ep;
        longint t_bit [8];
        t_pc = 0; t_ep = 0; e_max = 0;
        for (int j = 0; j < 8; j++) t_bit[j] = 0;
        for (int a = 1; a < 16; a++)
            for (int b = 1; b <= (tri_m ? a : 15); b++) begin
                int ex, ax, ab;
                logic [7:0] d;
                ex = a * b;
                ax = int'(approx_f(k, 4'(a), 4'(b)));
                d = 8'(ex) ^ 8'(ax);
                t_pc++;
                if (d != 0) t_ep++;
                for (int j = 0; j < 8; j++) t_bit[j] += longint'(d[j]);
                ab = ex > ax ? ex - ax : ax - ex;
                if (ab > e_max) e_max = ab;
            end
        e_pairs = int'(t_pc);
        e_sat = (t_pc > cmax) || (t_ep > cmax);
        e_pc = int'(t_pc > cmax ? cmax : t_pc);
        e_ep = int'(t_ep > cmax ? cmax : t_ep);
        for (int j = 0; j < 8; j++) begin
            if (t_bit[j] > cmax) e_sat = 1'b1;
            e_bit[j] = int'(t_bit[j] > cmax ? cmax : t_bit[j]);
        end
    endtask

    task automatic test_sweep(input int i, input int k, input bit tri_m, input string tag);
        int cyc, lat;
        lat = (i == 1) ? 2 : 0;
        kind[i] = k;
        model(k, tri_m, 64'hFFFF_FFFF);
        @(negedge clk);
        start[i] = 1'b1;
        mode_tri[i] = tri_m;
        @(posedge clk); #1;
        start[i] = 1'b0;
        cyc = 0;
        while (!done[i] && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== e_pairs + lat + 2) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, cyc, e_pairs + lat + 2); end
        checks++; if (pc[i] !== 32'(e_pc)) begin errors++; $display("FAIL %s pair_count got %0d want %0d", tag, pc[i], e_pc); end
        checks++; if (ep[i] !== 32'(e_ep)) begin errors++; $display("FAIL %s err_pairs got %0d want %0d", tag, ep[i], e_ep); end
        checks++; if (max_err[i] !== 8'(e_max)) begin errors++; $display("FAIL %s max_abs_err got %0d want %0d", tag, max_err[i], e_max); end
        checks++; if (sat[i] !== e_sat) begin errors++; $display("FAIL %s sat got %0b want %0b", tag, sat[i], e_sat); end
        checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL %s busy got %0b want 0", tag, busy[i]); end
        checks++; if (op_a[i] !== 4'd15 || op_b[i] !== 4'd15) begin errors++; $display("FAIL %s op_hold got %0d,%0d want 15,15", tag, op_a[i], op_b[i]); end
        for (int j = 0; j < 8; j++) begin
            rd_idx[i] = 3'(j);
            #1;
            checks++; if (rc[i] !== 32'(e_bit[j])) begin errors++; $display("FAIL %s bit%0d got %0d want %0d", tag, j, rc[i], e_bit[j]); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done[i] !== 1'b1) begin errors++; $display("FAIL %s done_hold got %0b want 1", tag, done[i]); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0 || sat[0] !== 1'b0) begin errors++; $display("FAIL reset flags got %0b%0b%0b want 000", busy[0], done[0], sat[0]); end
        checks++; if (op_a[0] !== 4'd0 || op_b[0] !== 4'd0) begin errors++; $display("FAIL reset ops got %0d,%0d want 0,0", op_a[0], op_b[0]); end
        checks++; if (pc[0] !== 32'd0 || ep[0] !== 32'd0) begin errors++; $display("FAIL reset counts got %0d,%0d want 0,0", pc[0], ep[0]); end
        checks++; if (max_err[0] !== 8'd0) begin errors++; $display("FAIL reset max got %0d want 0", max_err[0]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_trunc();
        test_sweep(0, 0, 1'b1, "trunc_tri");
        test_sweep(0, 0, 1'b0, "trunc_full");
    endtask

    task automatic test_bit0();
        test_sweep(0, 1, 1'b1, "bit0_tri");
        test_sweep(0, 1, 1'b0, "bit0_full");
    endtask

    task automatic test_latency();
        test_sweep(1, 0, 1'b1, "lat2_tri");
        test_sweep(1, 1, 1'b0, "lat2_full");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 256; j++) lut[j] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
            test_sweep(int'($urandom_range(0, 1)), 3, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_abort();
        int cyc;
        kind[1] = 0;
        model(0, 1'b1, 64'hFFFF_FFFF);
        @(negedge clk);
        start[1] = 1'b1;
        mode_tri[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start[1] = 1'b1;
        mode_tri[1] = 1'b0;
        @(posedge clk); #1;
        start[1] = 1'b0;
        cyc = 21;
        while (!done[1] && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== e_pairs + 4) begin errors++; $display("FAIL ignore_start latency got %0d want %0d", cyc, e_pairs + 4); end
        checks++; if (pc[1] !== 32'(e_pc)) begin errors++; $display("FAIL ignore_start pair_count got %0d want %0d", pc[1], e_pc); end
        @(negedge clk);
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rd_idx[1] = 3'd7;
        #1;
        checks++; if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin errors++; $display("FAIL abort flags got %0b%0b want 00", busy[1], done[1]); end
        checks++; if (pc[1] !== 32'd0 || ep[1] !== 32'd0 || rc[1] !== 32'd0) begin errors++; $display("FAIL abort counts got %0d,%0d,%0d want 0,0,0", pc[1], ep[1], rc[1]); end
        checks++; if (max_err[1] !== 8'd0 || op_a[1] !== 4'd0) begin errors++; $display("FAIL abort max/op got %0d,%0d want 0,0", max_err[1], op_a[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        test_sweep(1, 0, 1'b1, "after_abort");
    endtask

    task automatic test_saturation();
        int cyc;
        kind[2] = 2;
        model(2, 1'b0, 63);
        @(negedge clk);
        start[2] = 1'b1;
        mode_tri[2] = 1'b0;
        @(posedge clk); #1;
        start[2] = 1'b0;
        cyc = 0;
        while (!done[2] && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== e_pairs + 2) begin errors++; $display("FAIL sat latency got %0d want %0d", cyc, e_pairs + 2); end
        checks++; if (pc2 !== 6'(e_pc)) begin errors++; $display("FAIL sat pair_count got %0d want %0d", pc2, e_pc); end
        checks++; if (ep2 !== 6'(e_ep)) begin errors++; $display("FAIL sat err_pairs got %0d want %0d", ep2, e_ep); end
        checks++; if (sat[2] !== e_sat) begin errors++; $display("FAIL sat flag got %0b want %0b", sat[2], e_sat); end
        checks++; if (max_err[2] !== 8'(e_max)) begin errors++; $display("FAIL sat max_abs_err got %0d want %0d", max_err[2], e_max); end
        for (int j = 0; j < 8; j++) begin
            rd_idx[2] = 3'(j);
            #1;
            checks++; if (rc2 !== 6'(e_bit[j])) begin errors++; $display("FAIL sat bit%0d got %0d want %0d", j, rc2, e_bit[j]); end
        end
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            start[j] = 1'b0;
            mode_tri[j] = 1'b0;
            rd_idx[j] = 3'd0;
        end
        for (int j = 0; j < 256; j++) lut[j] = 7'd0;
        test_reset();
        test_trunc();
        test_bit0();
        test_latency();
        test_back_to_back();
        test_abort();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
